// File: rtl/dma_apb_master_if.sv
// Bundle of the command/completion port and the APB requester bus of dma_apb_master.
// The master modport is the requester's view; slave is the host plus DMA register block.
interface dma_apb_master_if #(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [REG_DATA_WIDTH-1:0] cmd_src;
  logic [REG_DATA_WIDTH-1:0] cmd_dest;
  logic [REG_DATA_WIDTH-1:0] cmd_size;
  logic [1:0]                cmd_mode;
  logic                      done_valid;
  logic [1:0]                done_status;
  logic [REG_DATA_WIDTH-1:0] rd_data;
  logic                      busy;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [REG_ADDR_WIDTH-1:0] PADDR;
  logic [REG_DATA_WIDTH-1:0] PWDATA;
  logic                      PREADY;
  logic [REG_DATA_WIDTH-1:0] PRDATA;
  logic                      INTR;

  modport master (
    input  cmd_valid, cmd_src, cmd_dest, cmd_size, cmd_mode,
    input  PREADY, PRDATA, INTR,
    output cmd_ready, done_valid, done_status, rd_data, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dest, cmd_size, cmd_mode,
    output PREADY, PRDATA, INTR,
    input  cmd_ready, done_valid, done_status, rd_data, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/dma_apb_master.sv
// APB requester that programs the DMA register block (src, dest, size, then mode),
// waits for the DMA interrupt, reads mode back and reports one status per command.
module dma_apb_master #(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int APB_TIMEOUT    = 16,
  parameter int INTR_TIMEOUT   = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  dma_apb_master_if.master      bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_INTR = 3'd3,
    S_RD_SETUP  = 3'd4,
    S_RD_ACCESS = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam int CNT_W = 17;
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_APB_TO   = 2'd1;
  localparam logic [1:0] ST_INTR_TO  = 2'd2;
  localparam logic [1:0] ST_MISMATCH = 2'd3;

  state_t                    state, state_d;
  logic [1:0]                idx, idx_d;
  logic [CNT_W-1:0]          cnt;
  logic [REG_DATA_WIDTH-1:0] src_q, dest_q, size_q;
  logic [REG_DATA_WIDTH-1:0] src_d, dest_d, size_d;
  logic [1:0]                mode_q, mode_d;
  logic                      intr_seen;
  logic [1:0]                status_d;
  logic                      cmd_ready;
  logic                      accept;
  logic                      apb_to, intr_to;

  logic                      psel_q, penable_q, pwrite_q;
  logic [REG_ADDR_WIDTH-1:0] paddr_q;
  logic [REG_DATA_WIDTH-1:0] pwdata_q;
  logic                      psel_d, penable_d, pwrite_d;
  logic [REG_ADDR_WIDTH-1:0] paddr_d;
  logic [REG_DATA_WIDTH-1:0] pwdata_d;
  logic                      done_valid_q;
  logic [1:0]                done_status_q;
  logic [REG_DATA_WIDTH-1:0] rd_data_q;

  // Command handshake: a command transfers on the rising CLK edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE and never while RST is high.
  assign cmd_ready = (state == S_IDLE) && !RST;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign apb_to    = (cnt == CNT_W'(APB_TIMEOUT - 1));
  assign intr_to   = (cnt == CNT_W'(INTR_TIMEOUT - 1));

  // State register plus every registered output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      src_q         <= '0;
      dest_q        <= '0;
      size_q        <= '0;
      mode_q        <= '0;
      intr_seen     <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      done_valid_q  <= 1'b0;
      done_status_q <= '0;
      rd_data_q     <= '0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      src_q  <= src_d;
      dest_q <= dest_d;
      size_q <= size_d;
      mode_q <= mode_d;

      // One counter serves both the APB wait and the interrupt wait.
      if (state_d != state)
        cnt <= '0;
      else if (state == S_ACCESS || state == S_RD_ACCESS || state == S_WAIT_INTR)
        cnt <= cnt + 1'b1;

      // The slave may fire INTR while the mode write is still in its access phase.
      if (state == S_ACCESS && idx == 2'd3 && bus.INTR)
        intr_seen <= 1'b1;
      else if (state != S_ACCESS)
        intr_seen <= 1'b0;

      if (state == S_RD_ACCESS && bus.PREADY)
        rd_data_q <= bus.PRDATA;

      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      done_valid_q  <= (state_d == S_DONE);
      done_status_q <= (state_d == S_DONE) ? status_d : 2'd0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    status_d = ST_OK;
    src_d    = src_q;
    dest_d   = dest_q;
    size_d   = size_q;
    mode_d   = mode_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          src_d   = bus.cmd_src;
          dest_d  = bus.cmd_dest;
          size_d  = bus.cmd_size;
          mode_d  = bus.cmd_mode;
          idx_d   = 2'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) begin
          if (idx != 2'd3) begin
            idx_d   = idx + 2'd1;
            state_d = S_SETUP;
          end else if (mode_q != 2'd0) begin
            state_d = S_WAIT_INTR;
          end else begin
            state_d  = S_DONE;
            status_d = ST_OK;
          end
        end else if (apb_to) begin
          state_d  = S_DONE;
          status_d = ST_APB_TO;
        end
      end
      S_WAIT_INTR: begin
        if (bus.INTR || intr_seen) begin
          state_d = S_RD_SETUP;
        end else if (intr_to) begin
          state_d  = S_DONE;
          status_d = ST_INTR_TO;
        end
      end
      S_RD_SETUP: state_d = S_RD_ACCESS;
      S_RD_ACCESS: begin
        if (bus.PREADY) begin
          state_d  = S_DONE;
          status_d = (bus.PRDATA == '0) ? ST_OK : ST_MISMATCH;
        end else if (apb_to) begin
          state_d  = S_DONE;
          status_d = ST_APB_TO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic, decoded from the upcoming state so the bus pins come straight from flops.
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    case (state_d)
      S_SETUP, S_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_ACCESS);
        pwrite_d  = 1'b1;
        paddr_d   = REG_ADDR_WIDTH'({idx_d, 2'b00});
        case (idx_d)
          2'd0:    pwdata_d = src_d;
          2'd1:    pwdata_d = dest_d;
          2'd2:    pwdata_d = size_d;
          default: pwdata_d = REG_DATA_WIDTH'(mode_d);
        endcase
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_RD_ACCESS);
        paddr_d   = REG_ADDR_WIDTH'(12);
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.busy        = (state != S_IDLE);
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_status = done_status_q;
  assign bus.rd_data     = rd_data_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_dma_apb_master.sv
// Directed bench for dma_apb_master: a DMA-like APB slave with a write scoreboard,
// plus hand-timed command scenarios covering every completion status and mid-transfer reset.
module tb_dma_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  dma_apb_master_if #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) bus ();

  dma_apb_master #(
    .REG_ADDR_WIDTH(AW),
    .REG_DATA_WIDTH(DW),
    .APB_TIMEOUT(16),
    .INTR_TIMEOUT(100)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_seen = 0;
  logic [63:0] exp_q[$];
  bit          slave_en = 1'b1;
  bit          pulse_ready = 1'b0;
  logic [31:0] rd_value = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one command in IDLE; return one cycle later with the DUT in SETUP.
  task automatic issue(input logic [31:0] src, input logic [31:0] dest,
                       input logic [31:0] size, input logic [1:0] mode, input int n_push);
    logic [63:0] w[4];
    w[0] = {32'h00, src};
    w[1] = {32'h04, dest};
    w[2] = {32'h08, size};
    w[3] = {32'h0C, 30'd0, mode};
    for (int i = 0; i < n_push; i++) exp_q.push_back(w[i]);
    check("issue_ready", bus.cmd_ready, 1);
    bus.cmd_src   = src;
    bus.cmd_dest  = dest;
    bus.cmd_size  = size;
    bus.cmd_mode  = mode;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!bus.done_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!bus.done_valid) check("done_bound", 0, 1);
  endtask

  // DMA-like slave: PREADY in the 2nd access cycle, scoreboard on completed writes.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    forever begin
      @(negedge CLK);
      if (bus.PSEL && bus.PENABLE) acc_cnt++;
      else acc_cnt = 0;
      bus.PREADY = (slave_en && acc_cnt >= 2) || pulse_ready;
      bus.PRDATA = rd_value;
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
        wr_seen++;
        if (exp_q.size() == 0) check("wr_extra", 1, 0);
        else check("wr", {bus.PADDR, bus.PWDATA}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int wr_before;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dest  = '0;
    bus.cmd_size  = '0;
    bus.cmd_mode  = '0;
    bus.INTR      = 1'b0;

    // Reset values
    #1;
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_psel", bus.PSEL, 0);
    check("rst_pen", bus.PENABLE, 0);
    check("rst_done", bus.done_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd", bus.rd_data, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("post_rst_ready", bus.cmd_ready, 1);
    check("post_rst_state", dbg_state, 0);

    // Mode 0: four writes, continuous PSEL, PENABLE in the 2nd/3rd cycle of each write
    issue(32'h100, 32'h200, 32'h40, 2'd0, 4);
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t1_psel_c%0d", c), bus.PSEL, 1);
      check($sformatf("t1_pen_c%0d", c), bus.PENABLE, (c % 3) != 1);
      tick();
    end
    check("t1_done", bus.done_valid, 1);
    check("t1_status", bus.done_status, 0);
    check("t1_psel_off", bus.PSEL, 0);
    tick();
    check("t1_done_pulse", bus.done_valid, 0);
    check("t1_ready", bus.cmd_ready, 1);
    check("t1_sb_empty", exp_q.size(), 0);

    // Mode 1: INTR 20 cycles after the mode write, stray PREADY in WAIT_INTR
    issue(32'h1000, 32'h2000, 32'h80, 2'd1, 4);
    repeat (12) tick();
    check("t2_wait", dbg_state, 3);
    check("t2_psel", bus.PSEL, 0);
    for (int i = 0; i < 19; i++) begin
      pulse_ready = (i == 5);
      tick();
    end
    pulse_ready = 1'b0;
    check("t2_still_wait", dbg_state, 3);
    bus.INTR = 1'b1;
    pulse_ready = 1'b1;
    tick();
    bus.INTR = 1'b0;
    pulse_ready = 1'b0;
    check("t2_rd_state", dbg_state, 4);
    check("t2_rd_psel", bus.PSEL, 1);
    check("t2_rd_pen", bus.PENABLE, 0);
    check("t2_rd_pwrite", bus.PWRITE, 0);
    check("t2_rd_paddr", bus.PADDR, 32'h0C);
    wait_done(10, cyc);
    check("t2_lat", cyc, 3);
    check("t2_status", bus.done_status, 0);
    check("t2_rd_data", bus.rd_data, 0);
    tick();

    // Mode 3 with no interrupt: INTR timeout after 100 WAIT_INTR cycles
    issue(32'hA0, 32'hB0, 32'hC0, 2'd3, 4);
    repeat (12) tick();
    check("t3_wait", dbg_state, 3);
    wait_done(150, cyc);
    check("t3_lat", cyc, 100);
    check("t3_status", bus.done_status, 2);
    check("t3_psel", bus.PSEL, 0);
    tick();

    // APB timeout on the first write
    slave_en = 1'b0;
    wr_before = wr_seen;
    issue(32'h300, 32'h400, 32'h10, 2'd1, 0);
    wait_done(40, cyc);
    check("t4_lat", cyc, 17);
    check("t4_status", bus.done_status, 1);
    check("t4_psel", bus.PSEL, 0);
    check("t4_pen", bus.PENABLE, 0);
    repeat (3) tick();
    check("t4_idle", dbg_state, 0);
    check("t4_no_more_psel", bus.PSEL, 0);
    check("t4_no_writes", wr_seen - wr_before, 0);
    slave_en = 1'b1;

    // Early INTR during the mode write, readback returns 0x2
    rd_value = 32'h2;
    issue(32'h500, 32'h600, 32'h20, 2'd2, 4);
    repeat (10) tick();
    check("t5_mode_acc", dbg_state, 2);
    bus.INTR = 1'b1;
    tick();
    bus.INTR = 1'b0;
    tick();
    check("t5_wait", dbg_state, 3);
    wait_done(10, cyc);
    check("t5_lat", cyc, 4);
    check("t5_status", bus.done_status, 3);
    check("t5_rd_data", bus.rd_data, 32'h2);
    rd_value = 32'h0;
    tick();

    // Reset during the 2nd write's access phase
    issue(32'hAAA, 32'hBBB, 32'hCC, 2'd1, 1);
    repeat (4) tick();
    check("t6_pen_pre", bus.PENABLE, 1);
    #2 RST = 1'b1;
    #1;
    check("t6_psel", bus.PSEL, 0);
    check("t6_pen", bus.PENABLE, 0);
    check("t6_ready_in_rst", bus.cmd_ready, 0);
    check("t6_busy", bus.busy, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("t6_ready", bus.cmd_ready, 1);
    check("t6_state", dbg_state, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t6_no_done_%0d", i), bus.done_valid, 0);
    end
    check("t6_sb_empty", exp_q.size(), 0);

    // Recovery: a normal mode-0 command after reset
    issue(32'h10, 32'h20, 32'h30, 2'd0, 4);
    wait_done(20, cyc);
    check("t7_lat", cyc, 12);
    check("t7_status", bus.done_status, 0);
    tick();
    check("t7_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
